// File: rtl/ctrl_hazard_sb.sv
// ctrl_hazard_sb: pipeline stall/flush controller with a long-latency
// writeback scoreboard, a halt/drain/step sequencer for debug and bus
// halts, and a saturating count of front-end stall cycles.
module ctrl_hazard_sb #(
    parameter int NUM_STAGES     = 5,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 1 << REG_ADDR_WIDTH,
    parameter int DRAIN_CYCLES   = 3,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_halt_req,
    input  logic                      i_step,
    input  logic                      i_trap,
    input  logic                      i_x_branch_taken,
    input  logic                      i_d_rs1_rd_sig,
    input  logic                      i_d_rs2_rd_sig,
    input  logic [REG_ADDR_WIDTH-1:0] i_d_rs1_rd_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_d_rs2_rd_addr,
    input  logic                      i_d_rd_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_d_rd_wr_addr,
    input  logic                      i_x_rd_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_x_rd_wr_addr,
    input  logic                      i_x_is_load,
    input  logic                      i_sb_issue,
    input  logic [REG_ADDR_WIDTH-1:0] i_sb_issue_addr,
    input  logic                      i_sb_done,
    input  logic [REG_ADDR_WIDTH-1:0] i_sb_done_addr,
    output logic [NUM_STAGES-1:0]     o_stall_vec,
    output logic [NUM_STAGES-1:0]     o_flush_vec,
    output logic                      o_halted,
    output logic                      o_sb_busy,
    output logic [CNT_WIDTH-1:0]      o_stall_cycles
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [NUM_STAGES-1:0]     VEC_NONE     = {NUM_STAGES{1'b0}};
    localparam logic [NUM_STAGES-1:0]     VEC_ALL      = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0]     STALL_PC_ID  = NUM_STAGES'(5'b00011);
    localparam logic [NUM_STAGES-1:0]     FLUSH_BUBBLE = NUM_STAGES'(5'b00100);
    localparam logic [NUM_STAGES-1:0]     FLUSH_BRANCH = NUM_STAGES'(5'b00110);
    localparam logic [NUM_STAGES-1:0]     FLUSH_TRAP   = NUM_STAGES'(5'b01110);
    localparam logic [DCW-1:0]            DRAIN_LOAD   = DCW'(DRAIN_CYCLES);
    localparam logic [DCW-1:0]            DRAIN_ZERO   = {DCW{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX      = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ZERO     = {CNT_WIDTH{1'b0}};
    localparam logic [NUM_REGS-1:0]       SB_ZERO      = {NUM_REGS{1'b0}};
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ZERO    = {REG_ADDR_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_HALTED = 3'd2,
        ST_STEP   = 3'd3,
        ST_RESUME = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [NUM_REGS-1:0]    sb_q, sb_d;
    logic [NUM_REGS-1:0]    sb_set_s, sb_clr_s;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   load_use_s;
    logic                   hz_s;
    logic                   sb_busy_s;
    logic [NUM_STAGES-1:0]  stall_s, flush_s;

    assign sb_busy_s = |sb_q;

    // Data hazard: pending long-latency writes (RAW/WAW) and load-use against EX
    always_comb begin
        load_use_s = 1'b0;
        if (i_x_is_load && i_x_rd_wr_en && (i_x_rd_wr_addr != ADDR_ZERO)) begin
            load_use_s = (i_d_rs1_rd_sig && (i_d_rs1_rd_addr == i_x_rd_wr_addr)) ||
                         (i_d_rs2_rd_sig && (i_d_rs2_rd_addr == i_x_rd_wr_addr));
        end else begin
            load_use_s = 1'b0;
        end
        hz_s = (i_d_rs1_rd_sig && sb_q[i_d_rs1_rd_addr]) ||
               (i_d_rs2_rd_sig && sb_q[i_d_rs2_rd_addr]) ||
               (i_d_rd_wr_en   && sb_q[i_d_rd_wr_addr])  ||
               load_use_s;
    end

    // Stall/flush vectors: sequencer stall beats trap beats branch beats hazard
    always_comb begin
        stall_s = VEC_NONE;
        flush_s = VEC_NONE;
        if (!i_rst_n) begin
            stall_s = VEC_NONE;
            flush_s = VEC_NONE;
        end else begin
            case (state_q)
                ST_HALTED, ST_RESUME: begin
                    stall_s = VEC_ALL;
                    flush_s = VEC_NONE;
                end
                ST_DRAIN: begin
                    // Redirects still flush while draining; the bubble stays on top.
                    stall_s = STALL_PC_ID;
                    if (i_trap) begin
                        flush_s = FLUSH_BUBBLE | FLUSH_TRAP;
                    end else if (i_x_branch_taken) begin
                        flush_s = FLUSH_BUBBLE | FLUSH_BRANCH;
                    end else begin
                        flush_s = FLUSH_BUBBLE;
                    end
                end
                default: begin
                    if (i_trap) begin
                        flush_s = FLUSH_TRAP;
                    end else if (i_x_branch_taken) begin
                        flush_s = FLUSH_BRANCH;
                    end else if (hz_s) begin
                        stall_s = STALL_PC_ID;
                        flush_s = FLUSH_BUBBLE;
                    end else begin
                        stall_s = VEC_NONE;
                        flush_s = VEC_NONE;
                    end
                end
            endcase
        end
    end

    // Halt sequencer next state and drain counter
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!i_halt_req) begin
                    state_d = ST_IDLE;
                end else if ((drain_cnt_q == DRAIN_ZERO) && !sb_busy_s) begin
                    state_d = ST_HALTED;
                end else if (drain_cnt_q != DRAIN_ZERO) begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                // Dropping the request wins over a coincident step pulse.
                if (!i_halt_req) begin
                    state_d = ST_RESUME;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                state_d     = ST_DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end
            ST_RESUME: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = DRAIN_ZERO;
            end
        endcase
    end

    // Scoreboard next value: clear on done, then set on issue so a new issue wins
    always_comb begin
        sb_set_s = SB_ZERO;
        sb_clr_s = SB_ZERO;
        if (i_sb_done) begin
            sb_clr_s[i_sb_done_addr] = 1'b1;
        end else begin
            sb_clr_s = SB_ZERO;
        end
        if (i_sb_issue && (i_sb_issue_addr != ADDR_ZERO)) begin
            sb_set_s[i_sb_issue_addr] = 1'b1;
        end else begin
            sb_set_s = SB_ZERO;
        end
        sb_d    = (sb_q & ~sb_clr_s) | sb_set_s;
        sb_d[0] = 1'b0;
    end

    // Saturating count of cycles in which the PC is held
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s[0] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= DRAIN_ZERO;
            sb_q        <= SB_ZERO;
            cnt_q       <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            sb_q        <= sb_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_stall_vec    = stall_s;
    assign o_flush_vec    = flush_s;
    assign o_halted       = (state_q == ST_HALTED);
    assign o_sb_busy      = sb_busy_s;
    assign o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_ctrl_hazard_sb.sv
// Testbench for ctrl_hazard_sb: table vectors, directed halt/step/scoreboard
// sequences and random stimulus against a behavioural model.
module tb_ctrl_hazard_sb;
    localparam int NS = 5;
    localparam int AW = 5;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3, M_RESUME = 4;

    logic clk = 1'b0;
    logic rst_n, halt_req, step_in, trap, br;
    logic r1_en, r2_en, rd_en, x_en, x_ld, issue, done;
    logic [AW-1:0] r1, r2, rd, x_rd, issue_addr, done_addr;
    logic [NS-1:0] stall_vec, flush_vec;
    logic halted, sb_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Behavioural model: set of pending registers, sequencer mode, drain budget, stall count
    bit pend[32];
    int mode = M_RUN;
    int drain_left = 0;
    longint unsigned cnt_m = 0;

    always #5 clk = ~clk;

    ctrl_hazard_sb dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt_req(halt_req), .i_step(step_in),
        .i_trap(trap), .i_x_branch_taken(br),
        .i_d_rs1_rd_sig(r1_en), .i_d_rs2_rd_sig(r2_en),
        .i_d_rs1_rd_addr(r1), .i_d_rs2_rd_addr(r2),
        .i_d_rd_wr_en(rd_en), .i_d_rd_wr_addr(rd),
        .i_x_rd_wr_en(x_en), .i_x_rd_wr_addr(x_rd), .i_x_is_load(x_ld),
        .i_sb_issue(issue), .i_sb_issue_addr(issue_addr),
        .i_sb_done(done), .i_sb_done_addr(done_addr),
        .o_stall_vec(stall_vec), .o_flush_vec(flush_vec), .o_halted(halted),
        .o_sb_busy(sb_busy), .o_stall_cycles(stall_cycles)
    );

    typedef struct {
        logic r1_en; logic [4:0] r1; logic r2_en; logic [4:0] r2;
        logic rd_en; logic [4:0] rd;
        logic x_en; logic [4:0] x_rd; logic x_ld;
        logic trap; logic br;
        logic [4:0] exp_stall; logic [4:0] exp_flush;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit pend_any();
        bit a;
        a = 1'b0;
        foreach (pend[i]) a |= pend[i];
        return a;
    endfunction

    // Expected {stall, flush} from the priority rules and current inputs
    function automatic logic [9:0] model_vecs();
        bit hz;
        logic [4:0] s, f;
        s = 5'b00000;
        f = 5'b00000;
        hz = (r1_en && pend[r1]) || (r2_en && pend[r2]) || (rd_en && pend[rd]) ||
             (x_ld && x_en && (x_rd != 5'd0) &&
              ((r1_en && r1 == x_rd) || (r2_en && r2 == x_rd)));
        if (!rst_n) begin
            s = 5'b00000;
        end else if (mode == M_HALT || mode == M_RESUME) begin
            s = 5'b11111;
        end else if (mode == M_DRAIN) begin
            s = 5'b00011;
            f = 5'b00100 | (trap ? 5'b01110 : (br ? 5'b00110 : 5'b00000));
        end else if (trap) begin
            f = 5'b01110;
        end else if (br) begin
            f = 5'b00110;
        end else if (hz) begin
            s = 5'b00011;
            f = 5'b00100;
        end
        return {s, f};
    endfunction

    task automatic model_edge(input logic stalled);
        bit busy_now;
        if (!rst_n) begin
            foreach (pend[i]) pend[i] = 1'b0;
            mode = M_RUN;
            drain_left = 0;
            cnt_m = 0;
            return;
        end
        busy_now = pend_any();
        if (stalled && cnt_m < 64'hFFFF_FFFF) cnt_m++;
        case (mode)
            M_RUN:    if (halt_req) begin mode = M_DRAIN; drain_left = 3; end
            M_DRAIN: begin
                if (!halt_req) mode = M_RUN;
                else if (drain_left == 0 && !busy_now) mode = M_HALT;
                else if (drain_left > 0) drain_left--;
            end
            M_HALT: begin
                if (!halt_req) mode = M_RESUME;
                else if (step_in) mode = M_STEP;
            end
            M_STEP:   begin mode = M_DRAIN; drain_left = 3; end
            default:  mode = M_RUN;
        endcase
        if (done) pend[done_addr] = 1'b0;
        if (issue && issue_addr != 5'd0) pend[issue_addr] = 1'b1;
    endtask

    // One clock: compare every output with the model, then advance both
    task automatic step(input string tag);
        logic [9:0] e;
        #1;
        e = model_vecs();
        chk({tag, " stall_vec"}, stall_vec, e[9:5]);
        chk({tag, " flush_vec"}, flush_vec, e[4:0]);
        chk({tag, " halted"}, halted, (mode == M_HALT));
        chk({tag, " sb_busy"}, sb_busy, pend_any());
        chk({tag, " stall_cycles"}, stall_cycles, cnt_m[31:0]);
        @(posedge clk);
        model_edge(e[5]);
        #1;
    endtask

    task automatic clear_inputs();
        halt_req = 1'b0; step_in = 1'b0; trap = 1'b0; br = 1'b0;
        r1_en = 1'b0; r2_en = 1'b0; rd_en = 1'b0; x_en = 1'b0; x_ld = 1'b0;
        issue = 1'b0; done = 1'b0;
        r1 = 5'd0; r2 = 5'd0; rd = 5'd0; x_rd = 5'd0; issue_addr = 5'd0; done_addr = 5'd0;
    endtask

    initial begin
        int n;
        logic [31:0] c0;
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        model_edge(1'b0);
        #1;
        rst_n = 1'b1;

        // r1_en r1 r2_en r2 rd_en rd x_en x_rd x_ld trap br -> stall flush
        vecs[0]  = '{1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00011, 5'b00100};
        vecs[1]  = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vecs[2]  = '{1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'b00011, 5'b00100};
        vecs[3]  = '{1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vecs[4]  = '{1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vecs[5]  = '{1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vecs[6]  = '{1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00110};
        vecs[7]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b01110};
        vecs[8]  = '{1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b01110};
        vecs[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vecs[10] = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'b00011, 5'b00100};

        foreach (vecs[i]) begin
            clear_inputs();
            r1_en = vecs[i].r1_en; r1 = vecs[i].r1; r2_en = vecs[i].r2_en; r2 = vecs[i].r2;
            rd_en = vecs[i].rd_en; rd = vecs[i].rd;
            x_en = vecs[i].x_en; x_rd = vecs[i].x_rd; x_ld = vecs[i].x_ld;
            trap = vecs[i].trap; br = vecs[i].br;
            #1;
            chk($sformatf("vec%0d stall", i), stall_vec, vecs[i].exp_stall);
            chk($sformatf("vec%0d flush", i), flush_vec, vecs[i].exp_flush);
            step("tbl");
        end

        // Reset clears a busy scoreboard and the stall counter
        clear_inputs();
        issue = 1'b1; issue_addr = 5'd5; step("rst_issue5");
        issue_addr = 5'd7; step("rst_issue7");
        clear_inputs();
        #1;
        chk("pre-reset busy", sb_busy, 1'b1);
        rst_n = 1'b0;
        step("reset");
        chk("reset sb_busy", sb_busy, 1'b0);
        chk("reset stall_vec", stall_vec, 5'b00000);
        chk("reset stall_cycles", stall_cycles, 32'd0);
        chk("reset halted", halted, 1'b0);
        rst_n = 1'b1;

        // Scoreboard RAW: stall until done, released the cycle after
        issue = 1'b1; issue_addr = 5'd9; step("sb_issue");
        clear_inputs();
        r2_en = 1'b1; r2 = 5'd9;
        #1; chk("sb raw stall", stall_vec, 5'b00011);
        step("sb_raw");
        step("sb_raw");
        done = 1'b1; done_addr = 5'd9;
        #1; chk("sb done-cycle stall", stall_vec, 5'b00011);
        step("sb_done");
        done = 1'b0;
        #1; chk("sb released", stall_vec, 5'b00000);
        clear_inputs();
        issue = 1'b1; issue_addr = 5'd9; done = 1'b1; done_addr = 5'd9;
        step("sb_same");
        clear_inputs();
        #1; chk("issue wins over done", sb_busy, 1'b1);
        r2_en = 1'b1; r2 = 5'd9; step("sb_still");
        clear_inputs();
        done = 1'b1; done_addr = 5'd9; step("sb_clear");
        // WAW against a pending destination
        clear_inputs();
        issue = 1'b1; issue_addr = 5'd12; step("waw_issue");
        clear_inputs();
        rd_en = 1'b1; rd = 5'd12;
        #1; chk("waw stall", stall_vec, 5'b00011);
        done = 1'b1; done_addr = 5'd12; step("waw_done");
        clear_inputs();
        step("waw_idle");

        // Halt with an outstanding entry: drain persists until done
        issue = 1'b1; issue_addr = 5'd4; step("h_issue");
        issue = 1'b0;
        halt_req = 1'b1; step("h_enter");
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("drain stall", stall_vec, 5'b00011);
            chk("drain not halted", halted, 1'b0);
            step("h_drain");
        end
        done = 1'b1; done_addr = 5'd4; step("h_done");
        done = 1'b0;
        n = 0;
        while (!halted && n < 10) begin step("h_wait"); n++; end
        chk("halt reached", halted, 1'b1);
        chk("halted stall", stall_vec, 5'b11111);
        chk("halted flush", flush_vec, 5'b00000);
        halt_req = 1'b0; step("h_release");
        chk("resume halted", halted, 1'b0);
        chk("resume stall", stall_vec, 5'b11111);
        step("h_resume");
        chk("idle after resume", stall_vec, 5'b00000);

        // Single step from HALTED
        halt_req = 1'b1;
        n = 0;
        while (!halted && n < 12) begin step("s_halt"); n++; end
        chk("step halt reached", halted, 1'b1);
        step_in = 1'b1; step("s_pulse");
        step_in = 1'b0;
        chk("step pc free", stall_vec[0], 1'b0);
        chk("step not halted", halted, 1'b0);
        c0 = stall_cycles;
        step("s_step");
        chk("no count in step", stall_cycles, c0);
        n = 0;
        while (!halted && n < 12) begin
            chk("step drain stall", stall_vec, 5'b00011);
            step("s_drain");
            n++;
        end
        chk("re-halted", halted, 1'b1);
        chk("drain at least 3", (n >= 3), 1'b1);
        halt_req = 1'b0; step("s_release");
        step("s_resume");

        // Random stimulus against the model
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
            step_in = ($urandom_range(0, 3) == 0);
            trap = ($urandom_range(0, 19) == 0);
            br = ($urandom_range(0, 9) == 0);
            r1_en = 1'($urandom_range(0, 1)); r1 = 5'($urandom_range(0, 7));
            r2_en = 1'($urandom_range(0, 1)); r2 = 5'($urandom_range(0, 7));
            rd_en = 1'($urandom_range(0, 1)); rd = 5'($urandom_range(0, 7));
            x_en = 1'($urandom_range(0, 1)); x_rd = 5'($urandom_range(0, 7));
            x_ld = 1'($urandom_range(0, 1));
            issue = ($urandom_range(0, 4) == 0); issue_addr = 5'($urandom_range(0, 7));
            done = ($urandom_range(0, 3) == 0); done_addr = 5'($urandom_range(0, 7));
            step("rand");
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
